// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and digit-slice helper for the 7-segment scan controller.
package seg7_pkg;

   localparam int SEG7_CODE_W = 4;

   typedef enum logic [0:0] {
      DEAD  = 1'b0,
      DRIVE = 1'b1
   } seg7_state_e;

   // Wide enough for the largest supported bank (8 digits); callers slice to NUM_DIGITS.
   localparam logic [7:0] ANODE_OFF = 8'hFF;

   function automatic logic [SEG7_CODE_W-1:0] get_digit(input logic [8*SEG7_CODE_W-1:0] vec,
                                                        input logic [2:0] k);
      return vec[{k, 2'b00} +: SEG7_CODE_W];
   endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timer: alternates DEAD_CYC dark cycles and ON_CYC drive cycles, done on each slot half's last cycle.
// en=0 parks the timer at the start of a DEAD phase.
module seg7_slot_timer
   import seg7_pkg::*;
#(
   parameter int ON_CYC   = 50000,
   parameter int DEAD_CYC = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic state,
   output logic done
);

   localparam int MAX_CYC = (ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [0:0] ST_DEAD  = 1'(DEAD);
   localparam logic [0:0] ST_DRIVE = 1'(DRIVE);

   logic [CNT_W-1:0] cnt;
   logic             term;

   assign term = (state == ST_DRIVE) ? (cnt == CNT_W'(ON_CYC - 1))
                                     : (cnt == CNT_W'(DEAD_CYC - 1));
   assign done = en & term;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_DEAD;
         cnt   <= '0;
      end else if (!en) begin
         state <= ST_DEAD;
         cnt   <= '0;
      end else if (term) begin
         state <= ~state;
         cnt   <= '0;
      end else begin
         cnt   <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode scan controller with dead-time and frame-boundary data commit.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int ON_CYC     = 50000,
   parameter int DEAD_CYC   = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              en,
   input  logic                              load,
   input  logic [SEG7_CODE_W*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]             blank_in,
   output logic [SEG7_CODE_W-1:0]            dig_code,
   output logic [NUM_DIGITS-1:0]             an_n,
   output logic                              frame_ack,
   output logic                              busy
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int DW    = SEG7_CODE_W * NUM_DIGITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [0:0]       ST_DRIVE = 1'(DRIVE);

   logic                  state;
   logic                  done;
   logic                  slot_end;
   logic                  commit;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_nxt;
   logic [DW-1:0]         stage_dig;
   logic [DW-1:0]         shadow_dig;
   logic [DW-1:0]         shadow_dig_nxt;
   logic [NUM_DIGITS-1:0] stage_blank;
   logic [NUM_DIGITS-1:0] shadow_blank;
   logic [NUM_DIGITS-1:0] auto_blank;

   seg7_slot_timer #(
      .ON_CYC   (ON_CYC),
      .DEAD_CYC (DEAD_CYC)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .state (state),
      .done  (done)
   );

   assign slot_end = done && (state == ST_DRIVE);
   // Disabling the scan is treated as a frame boundary so pending data is not held hostage.
   assign commit   = busy && ((slot_end && (idx == LAST_IDX)) || !en);

   assign shadow_dig_nxt = commit ? stage_dig : shadow_dig;

   always_comb begin
      idx_nxt = idx;
      if (!en)
         idx_nxt = '0;
      else if (slot_end)
         idx_nxt = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= '0;
         stage_dig    <= '0;
         stage_blank  <= '0;
         shadow_dig   <= '0;
         shadow_blank <= '1;
         busy         <= 1'b0;
         frame_ack    <= 1'b0;
         dig_code     <= '0;
      end else begin
         idx       <= idx_nxt;
         frame_ack <= commit;
         busy      <= load | (busy & ~commit);
         if (load) begin
            stage_dig   <= digits_in;
            stage_blank <= blank_in;
         end
         if (commit) begin
            shadow_dig   <= stage_dig;
            shadow_blank <= stage_blank;
         end
         // Code is set as the slot's dark phase begins, so the decoder settles before the anode fires.
         if (!en || slot_end)
            dig_code <= get_digit(32'(shadow_dig_nxt), 3'(idx_nxt));
      end
   end

`ifdef SEG7_LZB_EN
   logic zero_run;
   always_comb begin
      auto_blank = '0;
      zero_run   = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run      = zero_run && (get_digit(32'(shadow_dig), 3'(k)) == '0);
         auto_blank[k] = zero_run;
      end
   end
`else
   assign auto_blank = '0;
`endif

   always_comb begin
      an_n = ANODE_OFF[NUM_DIGITS-1:0];
      if ((state == ST_DRIVE) && !(shadow_blank[idx] || auto_blank[idx]))
         an_n[idx] = 1'b0;
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed-vector bench for seg7_scan_ctrl at NUM_DIGITS=4, ON_CYC=8, DEAD_CYC=2 (slot 10, frame 40 cycles).
module tb_seg7_scan_ctrl;

   typedef struct {
      int         cyc;
      logic       ld;
      logic [15:0] dig;
      logic [3:0] blk;
      logic [3:0] an;
      logic [3:0] code;
      logic       bsy;
      logic       ack;
   } vec_t;

`ifdef SEG7_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  blank_in;
   logic [3:0]  dig_code;
   logic [3:0]  an_n;
   logic        frame_ack;
   logic        busy;

   int   cyc;
   int   n_vec;
   int   n_err;
   vec_t vt[$];

   seg7_scan_ctrl #(
      .NUM_DIGITS (4),
      .ON_CYC     (8),
      .DEAD_CYC   (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .load      (load),
      .digits_in (digits_in),
      .blank_in  (blank_in),
      .dig_code  (dig_code),
      .an_n      (an_n),
      .frame_ack (frame_ack),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic add(input int c, input logic ld, input logic [15:0] d, input logic [3:0] b,
                      input logic [3:0] an, input logic [3:0] code, input logic bsy, input logic ack);
      vec_t v;
      v.cyc = c; v.ld = ld; v.dig = d; v.blk = b;
      v.an = an; v.code = code; v.bsy = bsy; v.ack = ack;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] an, input logic [3:0] code,
                       input logic bsy, input logic ack);
      chk({tag, ".an_n"}, an_n, an);
      chk({tag, ".dig_code"}, dig_code, code);
      chk({tag, ".busy"}, {3'b0, busy}, {3'b0, bsy});
      chk({tag, ".frame_ack"}, {3'b0, frame_ack}, {3'b0, ack});
   endtask

   // Each negedge marks one elapsed posedge; load is a single-edge strobe.
   task automatic goto(input int target);
      while (cyc < target) begin
         @(negedge clk);
         cyc++;
         load = 1'b0;
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] b);
      digits_in = d;
      blank_in  = b;
      load      = 1'b1;
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      rst_n = 1'b0; en = 1'b1; load = 1'b0; digits_in = '0; blank_in = '0;

      // Blank startup frame, then 4321 committed at the wrap.
      add(  0, 0, 16'h0, 4'h0, 4'hF, 4'h0, 0, 0);
      add(  1, 0, 16'h0, 4'h0, 4'hF, 4'h0, 0, 0);
      add(  2, 0, 16'h0, 4'h0, 4'hF, 4'h0, 0, 0);
      add(  5, 0, 16'h0, 4'h0, 4'hF, 4'h0, 0, 0);
      add( 15, 0, 16'h0, 4'h0, 4'hF, 4'h0, 0, 0);
      add( 20, 1, 16'h4321, 4'h0, 4'hF, 4'h0, 0, 0);
      add( 21, 0, 16'h0, 4'h0, 4'hF, 4'h0, 1, 0);
      add( 39, 0, 16'h0, 4'h0, 4'hF, 4'h0, 1, 0);
      add( 40, 0, 16'h0, 4'h0, 4'hF, 4'h1, 0, 1);
      add( 41, 0, 16'h0, 4'h0, 4'hF, 4'h1, 0, 0);
      add( 42, 0, 16'h0, 4'h0, 4'hE, 4'h1, 0, 0);
      add( 49, 0, 16'h0, 4'h0, 4'hE, 4'h1, 0, 0);
      add( 50, 0, 16'h0, 4'h0, 4'hF, 4'h2, 0, 0);
      add( 52, 0, 16'h0, 4'h0, 4'hD, 4'h2, 0, 0);
      add( 62, 0, 16'h0, 4'h0, 4'hB, 4'h3, 0, 0);
      add( 72, 0, 16'h0, 4'h0, 4'h7, 4'h4, 0, 0);
      add( 79, 0, 16'h0, 4'h0, 4'h7, 4'h4, 0, 0);
      add( 80, 0, 16'h0, 4'h0, 4'hF, 4'h1, 0, 0);
      // Two loads in one frame: newest wins, single ack.
      add( 82, 1, 16'h1111, 4'h0, 4'hE, 4'h1, 0, 0);
      add( 83, 0, 16'h0, 4'h0, 4'hE, 4'h1, 1, 0);
      add( 85, 1, 16'h2222, 4'h0, 4'hE, 4'h1, 1, 0);
      add( 86, 0, 16'h0, 4'h0, 4'hE, 4'h1, 1, 0);
      add(119, 0, 16'h0, 4'h0, 4'h7, 4'h4, 1, 0);
      add(120, 0, 16'h0, 4'h0, 4'hF, 4'h2, 0, 1);
      add(121, 0, 16'h0, 4'h0, 4'hF, 4'h2, 0, 0);
      add(122, 0, 16'h0, 4'h0, 4'hE, 4'h2, 0, 0);
      // Load on the exact commit edge.
      add(130, 1, 16'h4321, 4'h0, 4'hF, 4'h2, 0, 0);
      add(131, 0, 16'h0, 4'h0, 4'hF, 4'h2, 1, 0);
      add(132, 0, 16'h0, 4'h0, 4'hD, 4'h2, 1, 0);
      add(142, 0, 16'h0, 4'h0, 4'hB, 4'h2, 1, 0);
      add(152, 0, 16'h0, 4'h0, 4'h7, 4'h2, 1, 0);
      add(159, 1, 16'h5555, 4'h0, 4'h7, 4'h2, 1, 0);
      add(160, 0, 16'h0, 4'h0, 4'hF, 4'h1, 1, 1);
      add(161, 0, 16'h0, 4'h0, 4'hF, 4'h1, 1, 0);
      add(162, 0, 16'h0, 4'h0, 4'hE, 4'h1, 1, 0);
      add(172, 0, 16'h0, 4'h0, 4'hD, 4'h2, 1, 0);
      add(182, 0, 16'h0, 4'h0, 4'hB, 4'h3, 1, 0);
      add(192, 0, 16'h0, 4'h0, 4'h7, 4'h4, 1, 0);
      add(199, 0, 16'h0, 4'h0, 4'h7, 4'h4, 1, 0);
      add(200, 0, 16'h0, 4'h0, 4'hF, 4'h5, 0, 1);
      add(201, 0, 16'h0, 4'h0, 4'hF, 4'h5, 0, 0);
      add(202, 0, 16'h0, 4'h0, 4'hE, 4'h5, 0, 0);
      add(212, 0, 16'h0, 4'h0, 4'hD, 4'h5, 0, 0);
      // Explicit blank of digit 2.
      add(215, 1, 16'h4321, 4'h4, 4'hD, 4'h5, 0, 0);
      add(216, 0, 16'h0, 4'h0, 4'hD, 4'h5, 1, 0);
      add(240, 0, 16'h0, 4'h0, 4'hF, 4'h1, 0, 1);
      add(242, 0, 16'h0, 4'h0, 4'hE, 4'h1, 0, 0);
      add(252, 0, 16'h0, 4'h0, 4'hD, 4'h2, 0, 0);
      add(262, 0, 16'h0, 4'h0, 4'hF, 4'h3, 0, 0);
      add(269, 0, 16'h0, 4'h0, 4'hF, 4'h3, 0, 0);
      add(272, 0, 16'h0, 4'h0, 4'h7, 4'h4, 0, 0);
      // Leading zeros: dark only when the optional blanking is built in.
      add(275, 1, 16'h0021, 4'h0, 4'h7, 4'h4, 0, 0);
      add(276, 0, 16'h0, 4'h0, 4'h7, 4'h4, 1, 0);
      add(280, 0, 16'h0, 4'h0, 4'hF, 4'h1, 0, 1);
      add(282, 0, 16'h0, 4'h0, 4'hE, 4'h1, 0, 0);
      add(292, 0, 16'h0, 4'h0, 4'hD, 4'h2, 0, 0);
      add(302, 0, 16'h0, 4'h0, LZB ? 4'hF : 4'hB, 4'h0, 0, 0);
      add(305, 1, 16'h0000, 4'h0, LZB ? 4'hF : 4'hB, 4'h0, 0, 0);
      add(306, 0, 16'h0, 4'h0, LZB ? 4'hF : 4'hB, 4'h0, 1, 0);
      add(312, 0, 16'h0, 4'h0, LZB ? 4'hF : 4'h7, 4'h0, 1, 0);
      add(320, 0, 16'h0, 4'h0, 4'hF, 4'h0, 0, 1);
      add(322, 0, 16'h0, 4'h0, 4'hE, 4'h0, 0, 0);
      add(332, 0, 16'h0, 4'h0, LZB ? 4'hF : 4'hD, 4'h0, 0, 0);
      add(335, 1, 16'h4321, 4'h0, LZB ? 4'hF : 4'hD, 4'h0, 0, 0);
      add(336, 0, 16'h0, 4'h0, LZB ? 4'hF : 4'hD, 4'h0, 1, 0);
      add(360, 0, 16'h0, 4'h0, 4'hF, 4'h1, 0, 1);
      add(362, 0, 16'h0, 4'h0, 4'hE, 4'h1, 0, 0);

      repeat (2) @(negedge clk);
      chk4("in_reset", 4'hF, 4'h0, 1'b0, 1'b0);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         goto(vt[i].cyc);
         chk4($sformatf("vec%0d", i), vt[i].an, vt[i].code, vt[i].bsy, vt[i].ack);
         if (vt[i].ld) do_load(vt[i].dig, vt[i].blk);
      end

      // en dropped mid-DRIVE of digit 2; a pending load commits while disabled.
      goto(384);
      chk4("en_pre", 4'hB, 4'h3, 1'b0, 1'b0);
      en = 1'b0;
      goto(385);
      chk4("en_off", 4'hF, 4'h1, 1'b0, 1'b0);
      do_load(16'h5555, 4'h0);
      goto(386);
      chk4("en_off_load", 4'hF, 4'h1, 1'b1, 1'b0);
      goto(387);
      chk4("en_off_commit", 4'hF, 4'h5, 1'b0, 1'b1);
      goto(390);
      chk4("en_off_hold", 4'hF, 4'h5, 1'b0, 1'b0);
      en = 1'b1;
      goto(391);
      chk4("en_on_dead", 4'hF, 4'h5, 1'b0, 1'b0);
      goto(392);
      chk4("en_on_drive", 4'hE, 4'h5, 1'b0, 1'b0);

      // Asynchronous reset mid-DRIVE discards pending data.
      goto(393);
      do_load(16'h1234, 4'h0);
      goto(395);
      chk4("rst_pre", 4'hE, 4'h5, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk4("rst_async", 4'hF, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      chk4("rst_rel", 4'hF, 4'h0, 1'b0, 1'b0);
      do_load(16'h8765, 4'h0);
      goto(1);
      chk4("rst_load", 4'hF, 4'h0, 1'b1, 1'b0);
      goto(5);
      chk4("rst_blank", 4'hF, 4'h0, 1'b1, 1'b0);
      goto(40);
      chk4("rst_commit", 4'hF, 4'h5, 1'b0, 1'b1);
      goto(42);
      chk4("rst_d0", 4'hE, 4'h5, 1'b0, 1'b0);
      goto(52);
      chk4("rst_d1", 4'hD, 4'h6, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
